// File: rtl/aes_sbox_sched.sv
// Time-shared bank of FIPS-197 forward S-box lanes serving the round datapath (SubBytes)
// and the key schedule (SubWord), with alternating-priority arbitration between them.
`timescale 1ns/1ps

module aes_sbox_sched #(
   parameter int unsigned SBOX_LANES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           st_valid,
   output logic           st_ready,
   input  logic [127:0]   st_data,
   output logic           st_out_valid,
   output logic [127:0]   st_out_data,
   input  logic           key_valid,
   output logic           key_ready,
   input  logic [31:0]    key_word,
   output logic           key_out_valid,
   output logic [31:0]    key_out_word,
   output logic           busy
);

   localparam int unsigned ST_W   = 128;
   localparam int unsigned KEY_W  = 32;
   localparam int unsigned BEAT_W = 4;
   localparam int unsigned N_ST   = 16 / SBOX_LANES;
   localparam int unsigned N_KEY  = (4 + SBOX_LANES - 1) / SBOX_LANES;

   localparam logic GRANT_ST  = 1'b0;
   localparam logic GRANT_KEY = 1'b1;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SUB_ST   = 3'd1,
      SUB_KEY  = 3'd2,
      DONE_ST  = 3'd3,
      DONE_KEY = 3'd4
   } state_e;

   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   state_e              state_q, state_d;
   logic [ST_W-1:0]     buf_q, buf_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                last_grant_q, last_grant_d;
   logic                st_out_valid_q, st_out_valid_d;
   logic                key_out_valid_q, key_out_valid_d;
   logic [ST_W-1:0]     st_out_data_q, st_out_data_d;
   logic [KEY_W-1:0]    key_out_word_q, key_out_word_d;
   logic                busy_q, busy_d;
   logic [3:0]          byte_idx;
   logic [6:0]          bit_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         buf_q           <= '0;
         beat_q          <= '0;
         last_grant_q    <= GRANT_ST;
         st_out_valid_q  <= 1'b0;
         key_out_valid_q <= 1'b0;
         st_out_data_q   <= '0;
         key_out_word_q  <= '0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         buf_q           <= buf_d;
         beat_q          <= beat_d;
         last_grant_q    <= last_grant_d;
         st_out_valid_q  <= st_out_valid_d;
         key_out_valid_q <= key_out_valid_d;
         st_out_data_q   <= st_out_data_d;
         key_out_word_q  <= key_out_word_d;
         busy_q          <= busy_d;
      end
   end

   // Grant: only in IDLE, contention goes to whoever did not win last time.
   always_comb begin
      st_ready  = 1'b0;
      key_ready = 1'b0;
      if (rst_n && (state_q == IDLE)) begin
         if (st_valid && key_valid) begin
            st_ready  = (last_grant_q == GRANT_KEY);
            key_ready = (last_grant_q == GRANT_ST);
         end else begin
            st_ready  = st_valid;
            key_ready = key_valid;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (st_valid && st_ready) begin
               state_d = SUB_ST;
            end else if (key_valid && key_ready) begin
               state_d = SUB_KEY;
            end
         end
         SUB_ST: begin
            if (beat_q == BEAT_W'(N_ST - 1)) begin
               state_d = DONE_ST;
            end
         end
         SUB_KEY: begin
            if (beat_q == BEAT_W'(N_KEY - 1)) begin
               state_d = DONE_KEY;
            end
         end
         DONE_ST:  state_d = IDLE;
         DONE_KEY: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      buf_d          = buf_q;
      beat_d         = beat_q;
      last_grant_d   = last_grant_q;
      st_out_data_d  = st_out_data_q;
      key_out_word_d = key_out_word_q;
      byte_idx       = '0;
      bit_lo         = '0;
      case (state_q)
         IDLE: begin
            if (st_valid && st_ready) begin
               buf_d        = st_data;
               beat_d       = '0;
               last_grant_d = GRANT_ST;
            end else if (key_valid && key_ready) begin
               buf_d        = {96'h0, key_word};
               beat_d       = '0;
               last_grant_d = GRANT_KEY;
            end
         end
         SUB_ST, SUB_KEY: begin
            // In-place substitution of this beat's lane window.
            for (int unsigned l = 0; l < SBOX_LANES; l++) begin
               byte_idx = 4'(32'(beat_q) * SBOX_LANES + l);
               bit_lo   = {byte_idx, 3'b000};
               buf_d[bit_lo +: 8] = sbox_f(buf_q[bit_lo +: 8]);
            end
            beat_d = beat_q + BEAT_W'(1);
            if (state_d == DONE_ST) begin
               st_out_data_d = buf_d;
            end
            if (state_d == DONE_KEY) begin
               key_out_word_d = buf_d[KEY_W-1:0];
            end
         end
         default: ;
      endcase
      st_out_valid_d  = (state_d == DONE_ST);
      key_out_valid_d = (state_d == DONE_KEY);
      busy_d          = (state_d != IDLE);
   end

   assign st_out_valid  = st_out_valid_q;
   assign st_out_data   = st_out_data_q;
   assign key_out_valid = key_out_valid_q;
   assign key_out_word  = key_out_word_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched: three instances (4, 2 and 1 lanes) checked against
// hand-computed vectors and the FIPS-197 forward table.
`timescale 1ns/1ps

module tb_aes_sbox_sched;

   localparam int unsigned NI = 3;
   localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [31:0]  KEY_IN  = 32'hcf4f3c09;
   localparam logic [31:0]  KEY_OUT = 32'h8a84eb01;

   localparam logic [2047:0] SBOX_REF = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic         clk;
   logic         rst_n;
   logic         st_valid_a      [NI];
   logic         st_ready_a      [NI];
   logic [127:0] st_data_a       [NI];
   logic         st_out_valid_a  [NI];
   logic [127:0] st_out_data_a   [NI];
   logic         key_valid_a     [NI];
   logic         key_ready_a     [NI];
   logic [31:0]  key_word_a      [NI];
   logic         key_out_valid_a [NI];
   logic [31:0]  key_out_word_a  [NI];
   logic         busy_a          [NI];

   int errors = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   aes_sbox_sched #(.SBOX_LANES(4)) u_dut_l4 (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid_a[0]), .st_ready(st_ready_a[0]), .st_data(st_data_a[0]),
      .st_out_valid(st_out_valid_a[0]), .st_out_data(st_out_data_a[0]),
      .key_valid(key_valid_a[0]), .key_ready(key_ready_a[0]), .key_word(key_word_a[0]),
      .key_out_valid(key_out_valid_a[0]), .key_out_word(key_out_word_a[0]),
      .busy(busy_a[0])
   );

   aes_sbox_sched #(.SBOX_LANES(2)) u_dut_l2 (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid_a[1]), .st_ready(st_ready_a[1]), .st_data(st_data_a[1]),
      .st_out_valid(st_out_valid_a[1]), .st_out_data(st_out_data_a[1]),
      .key_valid(key_valid_a[1]), .key_ready(key_ready_a[1]), .key_word(key_word_a[1]),
      .key_out_valid(key_out_valid_a[1]), .key_out_word(key_out_word_a[1]),
      .busy(busy_a[1])
   );

   aes_sbox_sched #(.SBOX_LANES(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid_a[2]), .st_ready(st_ready_a[2]), .st_data(st_data_a[2]),
      .st_out_valid(st_out_valid_a[2]), .st_out_data(st_out_data_a[2]),
      .key_valid(key_valid_a[2]), .key_ready(key_ready_a[2]), .key_word(key_word_a[2]),
      .key_out_valid(key_out_valid_a[2]), .key_out_word(key_out_word_a[2]),
      .busy(busy_a[2])
   );

   function automatic logic [7:0] ref_sb(input logic [7:0] x);
      logic [2047:0] t;
      t = SBOX_REF;
      return t[2047 - 8*int'(x) -: 8];
   endfunction

   // Issue one state request on instance d; lat counts edges from handshake to out_valid.
   task automatic run_st(input int d, input logic [127:0] data, output logic [127:0] res,
                         output int lat, output bit pulse_ok);
      int n;
      st_data_a[d]  = data;
      st_valid_a[d] = 1'b1;
      #1;
      n = 0;
      while (st_ready_a[d] !== 1'b1 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 60) begin
         st_valid_a[d] = 1'b0; res = '0; lat = -1; pulse_ok = 1'b0;
         return;
      end
      @(posedge clk); #1;
      st_valid_a[d] = 1'b0;
      st_data_a[d]  = ~data;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (st_out_valid_a[d] !== 1'b1 && lat < 60);
      res = st_out_data_a[d];
      @(posedge clk); #1;
      pulse_ok = (st_out_valid_a[d] === 1'b0);
   endtask

   task automatic run_key(input int d, input logic [31:0] word, output logic [31:0] res,
                          output int lat, output bit pulse_ok);
      int n;
      key_word_a[d]  = word;
      key_valid_a[d] = 1'b1;
      #1;
      n = 0;
      while (key_ready_a[d] !== 1'b1 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 60) begin
         key_valid_a[d] = 1'b0; res = '0; lat = -1; pulse_ok = 1'b0;
         return;
      end
      @(posedge clk); #1;
      key_valid_a[d] = 1'b0;
      key_word_a[d]  = ~word;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (key_out_valid_a[d] !== 1'b1 && lat < 60);
      res = key_out_word_a[d];
      @(posedge clk); #1;
      pulse_ok = (key_out_valid_a[d] === 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      st_data_a[0]   = VEC_IN;
      key_word_a[0]  = KEY_IN;
      st_valid_a[0]  = 1'b1;
      key_valid_a[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (st_ready_a[0] !== 1'b0) begin errors++; $display("FAIL reset_st_ready: got %b want 0", st_ready_a[0]); end
      checks++; if (key_ready_a[0] !== 1'b0) begin errors++; $display("FAIL reset_key_ready: got %b want 0", key_ready_a[0]); end
      checks++; if (busy_a[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a[0]); end
      checks++; if (st_out_valid_a[0] !== 1'b0 || key_out_valid_a[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0/0", st_out_valid_a[0], key_out_valid_a[0]); end
      checks++; if (st_out_data_a[0] !== 128'h0) begin errors++; $display("FAIL reset_st_out_data: got %h want 0", st_out_data_a[0]); end
      checks++; if (key_out_word_a[0] !== 32'h0) begin errors++; $display("FAIL reset_key_out_word: got %h want 0", key_out_word_a[0]); end
   endtask

   // Both requesters held valid from reset: grants must alternate K,S,K,S at cycles 0,3,9,12.
   task automatic test_contention();
      int  gcyc [4] = '{default: -1};
      bit  gkey [4] = '{default: 1'b0};
      int  exp_cyc [4] = '{0, 3, 9, 12};
      int  k = 0;
      int  cyc = 0;
      int  n;
      rst_n = 1'b1;
      #1;
      while (k < 4 && cyc < 60) begin
         checks++;
         if (st_ready_a[0] === 1'b1 && key_ready_a[0] === 1'b1) begin
            errors++; $display("FAIL contention_one_ready: both ready at cycle %0d", cyc);
         end
         if (key_out_valid_a[0] === 1'b1) begin
            checks++;
            if (key_out_word_a[0] !== KEY_OUT) begin errors++; $display("FAIL contention_key_data: got %h want %h", key_out_word_a[0], KEY_OUT); end
         end
         if (st_out_valid_a[0] === 1'b1) begin
            checks++;
            if (st_out_data_a[0] !== VEC_OUT) begin errors++; $display("FAIL contention_st_data: got %h want %h", st_out_data_a[0], VEC_OUT); end
         end
         if (key_ready_a[0] === 1'b1) begin
            gkey[k] = 1'b1; gcyc[k] = cyc; k++;
         end else if (st_ready_a[0] === 1'b1) begin
            gkey[k] = 1'b0; gcyc[k] = cyc; k++;
         end
         @(posedge clk); #1; cyc++;
      end
      st_valid_a[0]  = 1'b0;
      key_valid_a[0] = 1'b0;
      n = 0;
      while (busy_a[0] === 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (gkey[i] !== ((i % 2) == 0)) begin errors++; $display("FAIL contention_grant_%0d: got key=%b want key=%b", i, gkey[i], (i % 2) == 0); end
         checks++;
         if (gcyc[i] != exp_cyc[i]) begin errors++; $display("FAIL contention_cycle_%0d: got %0d want %0d", i, gcyc[i], exp_cyc[i]); end
      end
   endtask

   task automatic test_state_l4();
      logic [127:0] res; int lat; bit p;
      run_st(0, VEC_IN, res, lat, p);
      checks++; if (res !== VEC_OUT) begin errors++; $display("FAIL st_l4_data: got %h want %h", res, VEC_OUT); end
      checks++; if (lat != 4) begin errors++; $display("FAIL st_l4_latency: got %0d want 4", lat); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL st_l4_pulse: valid not a single cycle"); end
   endtask

   task automatic test_key_l4();
      logic [31:0] res; int lat; bit p;
      run_key(0, KEY_IN, res, lat, p);
      checks++; if (res !== KEY_OUT) begin errors++; $display("FAIL key_l4_data: got %h want %h", res, KEY_OUT); end
      checks++; if (lat != 1) begin errors++; $display("FAIL key_l4_latency: got %0d want 1", lat); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL key_l4_pulse: valid not a single cycle"); end
   endtask

   // State 0 in flight while st_data toggles and the key side waits.
   task automatic test_inflight();
      int n; int lat;
      st_data_a[0]  = 128'h0;
      st_valid_a[0] = 1'b1;
      #1;
      n = 0;
      while (st_ready_a[0] !== 1'b1 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      checks++; if (n >= 60) begin errors++; $display("FAIL inflight_handshake: st_ready never rose"); end
      @(posedge clk); #1;
      st_valid_a[0]  = 1'b0;
      key_word_a[0]  = 32'h01020304;
      key_valid_a[0] = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
         st_data_a[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
         checks++;
         if (key_ready_a[0] !== 1'b0) begin errors++; $display("FAIL inflight_key_ready: got %b want 0 at edge %0d", key_ready_a[0], lat); end
      end while (st_out_valid_a[0] !== 1'b1 && lat < 20);
      checks++; if (lat != 4) begin errors++; $display("FAIL inflight_latency: got %0d want 4", lat); end
      checks++; if (st_out_data_a[0] !== {16{8'h63}}) begin errors++; $display("FAIL inflight_data: got %h want all 63", st_out_data_a[0]); end
      @(posedge clk); #1;
      checks++; if (st_out_valid_a[0] !== 1'b0) begin errors++; $display("FAIL inflight_st_pulse: got %b want 0", st_out_valid_a[0]); end
      checks++; if (key_ready_a[0] !== 1'b1) begin errors++; $display("FAIL inflight_key_ready_idle: got %b want 1", key_ready_a[0]); end
      @(posedge clk); #1;
      key_valid_a[0] = 1'b0;
      @(posedge clk); #1;
      checks++; if (key_out_valid_a[0] !== 1'b1) begin errors++; $display("FAIL inflight_key_valid: got %b want 1", key_out_valid_a[0]); end
      checks++; if (key_out_word_a[0] !== 32'h7c777bf2) begin errors++; $display("FAIL inflight_key_data: got %h want 7c777bf2", key_out_word_a[0]); end
      @(posedge clk); #1;
      checks++; if (key_out_valid_a[0] !== 1'b0) begin errors++; $display("FAIL inflight_key_pulse: got %b want 0", key_out_valid_a[0]); end
   endtask

   // Reset asserted during SUB_ST beat 2 aborts the op silently.
   task automatic test_reset_mid();
      int n; bit seen; logic [127:0] res; int lat; bit p;
      st_data_a[0]  = VEC_IN;
      st_valid_a[0] = 1'b1;
      #1;
      n = 0;
      while (st_ready_a[0] !== 1'b1 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      st_valid_a[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy_a[0]); end
      rst_n = 1'b0;
      st_valid_a[0] = 1'b1;
      #1;
      checks++; if (busy_a[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_a[0]); end
      checks++; if (st_out_valid_a[0] !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", st_out_valid_a[0]); end
      checks++; if (st_out_data_a[0] !== 128'h0) begin errors++; $display("FAIL rstmid_st_out_data: got %h want 0", st_out_data_a[0]); end
      checks++; if (key_out_word_a[0] !== 32'h0) begin errors++; $display("FAIL rstmid_key_out_word: got %h want 0", key_out_word_a[0]); end
      checks++; if (st_ready_a[0] !== 1'b0) begin errors++; $display("FAIL rstmid_st_ready: got %b want 0", st_ready_a[0]); end
      st_valid_a[0] = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (st_out_valid_a[0] === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse: st_out_valid seen after abort"); end
      run_st(0, {128{1'b1}}, res, lat, p);
      checks++; if (res !== {16{8'h16}}) begin errors++; $display("FAIL rstmid_after_data: got %h want all 16", res); end
      checks++; if (lat != 4) begin errors++; $display("FAIL rstmid_after_latency: got %0d want 4", lat); end
   endtask

   task automatic test_lanes1();
      logic [31:0] kres; logic [127:0] sres; int lat; bit p;
      run_key(2, KEY_IN, kres, lat, p);
      checks++; if (kres !== KEY_OUT) begin errors++; $display("FAIL l1_key_data: got %h want %h", kres, KEY_OUT); end
      checks++; if (lat != 4) begin errors++; $display("FAIL l1_key_latency: got %0d want 4", lat); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL l1_key_pulse: valid not a single cycle"); end
      run_st(2, VEC_IN, sres, lat, p);
      checks++; if (sres !== VEC_OUT) begin errors++; $display("FAIL l1_st_data: got %h want %h", sres, VEC_OUT); end
      checks++; if (lat != 16) begin errors++; $display("FAIL l1_st_latency: got %0d want 16", lat); end
   endtask

   task automatic test_sweep_l2();
      logic [127:0] data, expv, res; logic [31:0] kres; int lat; bit p;
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < 16; i++) begin
            data[8*i +: 8] = 8'(16*r + i);
            expv[8*i +: 8] = ref_sb(8'(16*r + i));
         end
         run_st(1, data, res, lat, p);
         checks++; if (res !== expv) begin errors++; $display("FAIL l2_sweep_data_%0d: got %h want %h", r, res, expv); end
         checks++; if (lat != 8) begin errors++; $display("FAIL l2_sweep_latency_%0d: got %0d want 8", r, lat); end
         checks++; if (p !== 1'b1) begin errors++; $display("FAIL l2_sweep_pulse_%0d: valid not a single cycle", r); end
      end
      run_key(1, KEY_IN, kres, lat, p);
      checks++; if (kres !== KEY_OUT) begin errors++; $display("FAIL l2_key_data: got %h want %h", kres, KEY_OUT); end
      checks++; if (lat != 2) begin errors++; $display("FAIL l2_key_latency: got %0d want 2", lat); end
   endtask

   initial begin
      for (int i = 0; i < int'(NI); i++) begin
         st_valid_a[i]  = 1'b0;
         st_data_a[i]   = '0;
         key_valid_a[i] = 1'b0;
         key_word_a[i]  = '0;
      end
      rst_n = 1'b0;
      test_reset();
      test_contention();
      test_state_l4();
      test_key_l4();
      test_inflight();
      test_reset_mid();
      test_lanes1();
      test_sweep_l2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
